sine_nco_ctrl: RTL and testbench
================================

SINE_NCO_CTRL -- requirements
Module: sine_nco_ctrl

Interface
REQ-001 Parameter ACC_WIDTH, default 24, phase accumulator / tuning word width.
REQ-002 Parameter PHASE_WIDTH, default 11, phase word width driven to the sine LUT.
REQ-003 Parameter LUT_LATENCY, default 2, sine LUT read latency in clocks, range 1-8.
REQ-004 i_clk  input  1  single clock; all state on rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_en  input  1  sample strobe; accumulator and sweep advance only when high.
REQ-007 i_ftw  input  ACC_WIDTH  tuning word (start frequency in sweep mode).
REQ-008 i_ftw_valid  input  1  tuning word offered.
REQ-009 o_ftw_ready  output  1  tuning word accepted this cycle if i_ftw_valid is high.
REQ-010 i_ftw_stop  input  ACC_WIDTH  sweep end tuning word, sampled at start.
REQ-011 i_step  input  ACC_WIDTH  sweep increment per enabled sample, sampled at start.
REQ-012 i_sweep  input  1  mode select at start: 0 fixed tone, 1 linear sweep.
REQ-013 i_start  input  1  one-cycle start request.
REQ-014 i_stop  input  1  one-cycle stop request.
REQ-015 o_phase  output  PHASE_WIDTH  to LUT i_phase; = acc[ACC_WIDTH-1 -: PHASE_WIDTH].
REQ-016 o_lut_en  output  1  to LUT i_en.
REQ-017 o_valid  output  1  LUT output valid for the sample issued LUT_LATENCY clocks earlier.
REQ-018 o_busy  output  1  high in any state other than IDLE.
REQ-019 o_sweep_done  output  1  one-cycle pulse when the sweep reaches i_ftw_stop.

Function
REQ-020 States IDLE, RUN, SWEEP; encoding free.
REQ-021 IDLE: i_start & ~i_stop -> SWEEP if i_sweep else RUN; otherwise stay.
REQ-022 RUN/SWEEP: i_stop -> IDLE next clock; acc, freq cleared to 0; i_stop wins over i_start and every other event.
REQ-023 i_start outside IDLE ignored.
REQ-024 Tuning register ftw_reg loads i_ftw on i_ftw_valid & o_ftw_ready; o_ftw_ready = 1 in IDLE and RUN, 0 in SWEEP.
REQ-025 Start cycle: freq <= i_ftw if i_ftw_valid else ftw_reg; stop_reg <= i_ftw_stop; step_reg <= i_step; acc <= 0.
REQ-026 RUN: load accepted in RUN updates freq next clock; acc not reset (phase-continuous).
REQ-027 RUN/SWEEP, i_en high: acc <= (acc + freq) mod 2^ACC_WIDTH; wrap-around silent.
REQ-028 SWEEP, i_en high: sum = freq + step_reg at ACC_WIDTH+1 bits; sum >= stop_reg or carry out -> freq <= stop_reg, o_sweep_done pulse, state -> RUN; else freq <= sum.
REQ-029 i_ftw_stop <= start freq at start: first enabled SWEEP sample saturates, pulses o_sweep_done, enters RUN.
REQ-030 step_reg = 0 in SWEEP: freq constant, no done until i_stop.
REQ-031 o_phase registered from acc, so LUT sees phase after update.
REQ-032 o_lut_en = registered (i_en & state != IDLE), aligned with o_phase.
REQ-033 o_valid = o_lut_en delayed LUT_LATENCY clocks by shift register; shift continues after i_stop so in-flight samples drain.
REQ-034 i_en low: acc, freq, state hold; o_lut_en 0 next clock.

Reset
REQ-035 Reset: state IDLE; acc, freq, ftw_reg, stop_reg, step_reg, o_phase = 0; o_lut_en, o_valid, o_busy, o_sweep_done = 0; o_ftw_ready 1.
REQ-036 Reset mid-sweep discards all state and pipeline contents; o_valid low first clock after release.

Verification (ACC_WIDTH 24, PHASE_WIDTH 11, LUT_LATENCY 2)
REQ-037 Load 0x002000, start i_sweep=0, i_en=1 -> o_phase 1,2,3,... one per clock; o_valid rises 2 clocks after o_lut_en.
REQ-038 ftw 0x7FF000, run to wrap -> o_phase wraps 2047->0 region with no glitch; o_busy stays 1.
REQ-039 Sweep start 0x002000, step 0x002000, stop 0x008000 -> freq 0x004000,0x006000,0x008000; o_sweep_done single pulse on third sample; RUN with o_ftw_ready 1.
REQ-040 i_start and i_stop same cycle in IDLE -> stays IDLE, o_busy 0; i_stop in SWEEP -> IDLE, o_phase 0, o_valid drains 2 clocks.
REQ-041 i_en toggling 1,0,1 in RUN -> o_phase advances only on enabled cycles; o_lut_en follows i_en one clock late.
REQ-042 i_rst asserted asynchronously mid-sweep -> all outputs reset values immediately; o_ftw_ready 1.

Source files
------------

// File: rtl/sine_nco_ctrl.sv
// Phase-accumulator NCO controller: fixed-tone or linear-sweep tuning,
// drives the phase/enable of an external sine LUT and tracks its read latency.
module sine_nco_ctrl #(
  parameter int ACC_WIDTH   = 24,
  parameter int PHASE_WIDTH = 11,
  parameter int LUT_LATENCY = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic [ACC_WIDTH-1:0]   i_ftw,
  input  logic                   i_ftw_valid,
  output logic                   o_ftw_ready,
  input  logic [ACC_WIDTH-1:0]   i_ftw_stop,
  input  logic [ACC_WIDTH-1:0]   i_step,
  input  logic                   i_sweep,
  input  logic                   i_start,
  input  logic                   i_stop,
  output logic [PHASE_WIDTH-1:0] o_phase,
  output logic                   o_lut_en,
  output logic                   o_valid,
  output logic                   o_busy,
  output logic                   o_sweep_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SWEEP = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [ACC_WIDTH-1:0]   r_freq;
  logic [ACC_WIDTH-1:0]   r_ftw;
  logic [ACC_WIDTH-1:0]   r_stop;
  logic [ACC_WIDTH-1:0]   r_step;
  logic [ACC_WIDTH-1:0]   w_acc_nxt;
  logic [ACC_WIDTH-1:0]   w_freq_nxt;
  logic [ACC_WIDTH:0]     w_sum;
  logic                   w_load;
  logic                   w_start;
  logic                   w_done;
  logic [PHASE_WIDTH-1:0] r_phase;
  logic                   r_lut_en;
  logic                   r_sweep_done;
  logic                   r_busy;
  logic                   r_ftw_ready;
  logic [LUT_LATENCY-1:0] r_vpipe;

  // Next-state, accumulator and frequency decisions; stop overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_freq_nxt  = r_freq;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_load      = i_ftw_valid & r_ftw_ready;
    // Extra bit keeps the carry so an overflowing sweep still saturates.
    w_sum       = {1'b0, r_freq} + {1'b0, r_step};
    case (r_state)
      ST_IDLE: begin
        if (i_start && !i_stop) begin
          w_start     = 1'b1;
          w_state_nxt = i_sweep ? ST_SWEEP : ST_RUN;
          w_acc_nxt   = '0;
          w_freq_nxt  = i_ftw_valid ? i_ftw : r_ftw;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          w_state_nxt = ST_IDLE;
          w_acc_nxt   = '0;
          w_freq_nxt  = '0;
        end else begin
          if (i_en) begin
            w_acc_nxt = r_acc + r_freq;
          end else begin
            w_acc_nxt = r_acc;
          end
          if (w_load) begin
            w_freq_nxt = i_ftw;
          end else begin
            w_freq_nxt = r_freq;
          end
        end
      end
      ST_SWEEP: begin
        if (i_stop) begin
          w_state_nxt = ST_IDLE;
          w_acc_nxt   = '0;
          w_freq_nxt  = '0;
        end else if (i_en) begin
          w_acc_nxt = r_acc + r_freq;
          if (w_sum >= {1'b0, r_stop}) begin
            w_freq_nxt  = r_stop;
            w_done      = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            w_freq_nxt = w_sum[ACC_WIDTH-1:0];
          end
        end else begin
          w_state_nxt = ST_SWEEP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_acc_nxt   = '0;
        w_freq_nxt  = '0;
      end
    endcase
  end

  // State register and tuning/sweep working registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_freq  <= '0;
      r_ftw   <= '0;
      r_stop  <= '0;
      r_step  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_freq  <= w_freq_nxt;
      if (w_load) begin
        r_ftw <= i_ftw;
      end
      if (w_start) begin
        r_stop <= i_ftw_stop;
        r_step <= i_step;
      end
    end
  end

  // Registered outputs; busy/ready follow the state they are about to describe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase      <= '0;
      r_lut_en     <= 1'b0;
      r_sweep_done <= 1'b0;
      r_busy       <= 1'b0;
      r_ftw_ready  <= 1'b1;
    end else begin
      r_phase      <= w_acc_nxt[ACC_WIDTH-1 -: PHASE_WIDTH];
      r_lut_en     <= i_en & (r_state != ST_IDLE);
      r_sweep_done <= w_done;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_ftw_ready  <= (w_state_nxt != ST_SWEEP);
    end
  end

  // LUT latency tracker; keeps shifting after a stop so issued reads drain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vpipe <= '0;
    end else begin
      r_vpipe[0] <= r_lut_en;
      for (int k = 1; k < LUT_LATENCY; k++) begin
        r_vpipe[k] <= r_vpipe[k-1];
      end
    end
  end

  assign o_phase      = r_phase;
  assign o_lut_en     = r_lut_en;
  assign o_valid      = r_vpipe[LUT_LATENCY-1];
  assign o_busy       = r_busy;
  assign o_sweep_done = r_sweep_done;
  assign o_ftw_ready  = r_ftw_ready;

endmodule

// File: tb/tb_sine_nco_ctrl.sv
// Scoreboard bench for sine_nco_ctrl: directed scenarios plus random traffic
// against a mode/arithmetic reference model.
module tb_sine_nco_ctrl;
  localparam int AW  = 24;
  localparam int PW  = 11;
  localparam int LAT = 2;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_en = 1'b0, i_ftw_valid = 1'b0, i_sweep = 1'b0;
  logic          i_start = 1'b0, i_stop = 1'b0;
  logic [AW-1:0] i_ftw = '0, i_ftw_stop = '0, i_step = '0;
  logic          o_ftw_ready, o_lut_en, o_valid, o_busy, o_sweep_done;
  logic [PW-1:0] o_phase;

  sine_nco_ctrl #(.ACC_WIDTH(AW), .PHASE_WIDTH(PW), .LUT_LATENCY(LAT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_ftw(i_ftw),
    .i_ftw_valid(i_ftw_valid), .o_ftw_ready(o_ftw_ready),
    .i_ftw_stop(i_ftw_stop), .i_step(i_step), .i_sweep(i_sweep),
    .i_start(i_start), .i_stop(i_stop), .o_phase(o_phase),
    .o_lut_en(o_lut_en), .o_valid(o_valid), .o_busy(o_busy),
    .o_sweep_done(o_sweep_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int unsigned phase;
    bit lut_en, valid, busy, done, ready;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;

  // Reference model: mode 0 idle, 1 fixed tone, 2 sweep.
  int      m_mode;
  longint  m_acc, m_freq, m_ftw, m_stop, m_step;
  bit      m_lut_hist[LAT+1];
  bit      m_done;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.phase  = int'(m_acc >> (AW - PW));
    e.lut_en = m_lut_hist[0];
    e.valid  = m_lut_hist[LAT];
    e.busy   = (m_mode != 0);
    e.done   = m_done;
    e.ready  = (m_mode != 2);
    return e;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_acc = 0; m_freq = 0; m_ftw = 0; m_stop = 0; m_step = 0; m_done = 0;
    for (int i = 0; i <= LAT; i++) m_lut_hist[i] = 0;
  endtask

  // One clock of stimulus; the model predicts the outputs after the next rising edge.
  task automatic cyc(input bit en, input bit fv, input longint ftw, input longint fstop,
                     input longint step, input bit sw, input bit start, input bit stop);
    bit load;
    longint s;
    @(negedge i_clk);
    i_en = en; i_ftw_valid = fv; i_ftw = ftw[AW-1:0]; i_ftw_stop = fstop[AW-1:0];
    i_step = step[AW-1:0]; i_sweep = sw; i_start = start; i_stop = stop;
    load = fv && (m_mode != 2);
    for (int i = LAT; i > 0; i--) m_lut_hist[i] = m_lut_hist[i-1];
    m_lut_hist[0] = en && (m_mode != 0);
    m_done = 0;
    if (m_mode == 0) begin
      if (start && !stop) begin
        m_mode = sw ? 2 : 1;
        m_acc  = 0;
        m_freq = fv ? ftw : m_ftw;
        m_stop = fstop;
        m_step = step;
      end
    end else if (stop) begin
      m_mode = 0; m_acc = 0; m_freq = 0;
    end else begin
      if (en) m_acc = (m_acc + m_freq) % (64'd1 << AW);
      if (m_mode == 1 && load) m_freq = ftw;
      else if (m_mode == 2 && en) begin
        s = m_freq + m_step;
        if (s >= m_stop) begin
          m_freq = m_stop; m_done = 1; m_mode = 1; done_pulses++;
        end else begin
          m_freq = s;
        end
      end
    end
    if (load) m_ftw = ftw;
    sb_q.push_back(model_out());
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) cyc(en, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: after every rising edge, compare DUT outputs with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("phase", longint'(o_phase), longint'(e.phase));
        chk("lut_en", longint'(o_lut_en), longint'(e.lut_en));
        chk("valid", longint'(o_valid), longint'(e.valid));
        chk("busy", longint'(o_busy), longint'(e.busy));
        chk("sweep_done", longint'(o_sweep_done), longint'(e.done));
        chk("ftw_ready", longint'(o_ftw_ready), longint'(e.ready));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_phase"}, longint'(o_phase), 0);
    chk({tag, "_lut_en"}, longint'(o_lut_en), 0);
    chk({tag, "_valid"}, longint'(o_valid), 0);
    chk({tag, "_busy"}, longint'(o_busy), 0);
    chk({tag, "_done"}, longint'(o_sweep_done), 0);
    chk({tag, "_ready"}, longint'(o_ftw_ready), 1);
  endtask

  initial begin
    int dp;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge i_clk);
    i_rst = 1'b0;

    // Fixed tone: 0x002000 gives one phase LSB per enabled sample.
    cyc(1, 1, 24'h002000, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    idle(10, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    idle(3, 0);

    // Large tuning word: accumulator wraps while busy stays high.
    cyc(0, 1, 24'h7FF000, 0, 0, 0, 1, 0);
    idle(12, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    idle(3, 0);

    // Sweep 0x2000 -> 0x8000 in 0x2000 steps: done on the third sample.
    dp = done_pulses;
    cyc(0, 1, 24'h002000, 24'h008000, 24'h002000, 1, 1, 0);
    idle(8, 1);
    chk("sweep_done_count", longint'(done_pulses - dp), 1);
    cyc(1, 1, 24'h003000, 0, 0, 0, 0, 0);
    idle(2, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    idle(3, 0);

    // Start and stop together in idle: nothing happens.
    cyc(1, 0, 0, 0, 0, 1, 1, 1);
    idle(2, 1);

    // Zero-step sweep, then stop mid-sweep with samples in flight.
    cyc(1, 1, 24'h010000, 24'h800000, 0, 1, 1, 0);
    idle(6, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    idle(4, 0);

    // Stop word at or below start word: first sample saturates; carry-out sweep too.
    cyc(0, 1, 24'h050000, 24'h040000, 24'h000100, 1, 1, 0);
    idle(3, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 24'hF00000, 24'hFFFFFF, 24'h800000, 1, 1, 0);
    idle(3, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);

    // Enable toggling in RUN.
    cyc(1, 1, 24'h004000, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) cyc(i % 2 == 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      longint f, st, sp;
      f  = $urandom_range(0, 32'h00FFFFFF);
      st = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 32'h00FFFFFF)) :
                                         f + longint'($urandom_range(0, 32'h0003FFFF));
      if (st > 64'hFFFFFF) st = 64'hFFFFFF;
      sp = ($urandom_range(0, 7) == 0) ? 0 : longint'($urandom_range(0, 32'h00004FFF));
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, f, st, sp,
          $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 1);

    // Asynchronous reset mid-sweep: outputs must clear without a clock edge.
    cyc(1, 1, 24'h001000, 24'hF00000, 24'h000800, 1, 1, 0);
    idle(5, 1);
    @(negedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    sb_q.delete();
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    idle(3, 1);
    cyc(1, 1, 24'h002000, 0, 0, 0, 1, 0);
    idle(6, 1);

    @(posedge i_clk);
    #2;
    chk("scoreboard_drained", longint'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
